// File: rtl/snd_mix_seq.sv
// Time-multiplexed audio mixer: snapshots NUM_CH PCM sources on each sample tick,
// runs one shared multiplier through a per-channel MAC pass and a master-volume pass.
module snd_mix_seq #(
    parameter int NUM_CH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_tick,
    input  logic [16*NUM_CH-1:0]  ch_pcm,
    input  logic [8*NUM_CH-1:0]   ch_gain,
    input  logic [NUM_CH-1:0]     ch_en,
    input  logic [7:0]            master_vol,
    input  logic                  clr_overrun,
    output logic [15:0]           pcm_out,
    output logic                  pcm_valid,
    output logic                  clip,
    output logic                  busy,
    output logic                  overrun
);

    localparam int ACC_W = 25 + $clog2(NUM_CH) + 1;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = 32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -32768;

    typedef enum logic [1:0] {IDLE, MAC, MASTER} state_t;

    state_t                   state, state_nx;
    logic [16*NUM_CH-1:0]     snap_pcm;
    logic [8*NUM_CH-1:0]      snap_gain;
    logic [NUM_CH-1:0]        snap_en;
    logic [7:0]               snap_vol;
    logic [IDX_W-1:0]         ch_idx;
    logic                     last_ch;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  mix;
    logic signed [15:0]       sat;
    logic                     clip_n;
    logic signed [15:0]       mul_a;
    logic signed [8:0]        mul_b;
    logic signed [24:0]       prod;

    assign busy    = (state != IDLE);
    assign last_ch = (ch_idx == IDX_W'(NUM_CH - 1));
    assign mix     = acc >>> 8;

    always_comb begin
        sat    = mix[15:0];
        clip_n = 1'b0;
        if (mix > SAT_MAX) begin
            sat    = 16'sh7FFF;
            clip_n = 1'b1;
        end else if (mix < SAT_MIN) begin
            sat    = -16'sd32768;
            clip_n = 1'b1;
        end
    end

    // Single shared multiplier; operands selected by phase.
    always_comb begin
        mul_a = snap_pcm[16*ch_idx +: 16];
        mul_b = {1'b0, snap_gain[8*ch_idx +: 8]};
        if (state == MASTER) begin
            mul_a = sat;
            mul_b = {1'b0, snap_vol};
        end
    end

    assign prod = mul_a * mul_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sample_tick) state_nx = MAC;
            MAC:     if (last_ch) state_nx = MASTER;
            MASTER:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_pcm  <= '0;
            snap_gain <= '0;
            snap_en   <= '0;
            snap_vol  <= '0;
            ch_idx    <= '0;
            acc       <= '0;
            pcm_out   <= '0;
            clip      <= 1'b0;
            pcm_valid <= 1'b0;
        end else begin
            pcm_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        snap_pcm  <= ch_pcm;
                        snap_gain <= ch_gain;
                        snap_en   <= ch_en;
                        snap_vol  <= master_vol;
                        acc       <= '0;
                        ch_idx    <= '0;
                    end
                end
                MAC: begin
                    if (snap_en[ch_idx]) acc <= acc + {{(ACC_W-25){prod[24]}}, prod};
                    if (!last_ch) ch_idx <= ch_idx + 1'b1;
                end
                MASTER: begin
                    pcm_out   <= prod[23:8];
                    clip      <= clip_n;
                    pcm_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    overrun <= 1'b0;
        else if (sample_tick && busy)  overrun <= 1'b1;
        else if (clr_overrun)          overrun <= 1'b0;
    end

endmodule

// File: tb/tb_snd_mix_seq.sv
// Self-checking bench for snd_mix_seq: integer-arithmetic mix model with a
// countdown timing model, compared every cycle, plus hand-computed literal checks.
module tb_snd_mix_seq;

    localparam int NUM_CH = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  sample_tick;
    logic [16*NUM_CH-1:0]  ch_pcm;
    logic [8*NUM_CH-1:0]   ch_gain;
    logic [NUM_CH-1:0]     ch_en;
    logic [7:0]            master_vol;
    logic                  clr_overrun;
    logic [15:0]           pcm_out;
    logic                  pcm_valid;
    logic                  clip;
    logic                  busy;
    logic                  overrun;

    int checks   = 0;
    int failures = 0;

    snd_mix_seq #(.NUM_CH(NUM_CH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .ch_pcm      (ch_pcm),
        .ch_gain     (ch_gain),
        .ch_en       (ch_en),
        .master_vol  (master_vol),
        .clr_overrun (clr_overrun),
        .pcm_out     (pcm_out),
        .pcm_valid   (pcm_valid),
        .clip        (clip),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Mixed sample from the arithmetic rules: returns {clip, pcm}.
    function automatic logic [16:0] mix_model(input logic [16*NUM_CH-1:0] pcm,
                                              input logic [8*NUM_CH-1:0]  gain,
                                              input logic [NUM_CH-1:0]    en,
                                              input logic [7:0]           vol);
        longint acc, mix, sat, o;
        acc = 0;
        for (int i = 0; i < NUM_CH; i++)
            if (en[i])
                acc += longint'($signed(pcm[16*i +: 16])) * longint'(gain[8*i +: 8]);
        mix = acc >>> 8;
        sat = (mix > 32767) ? 32767 : (mix < -32768) ? -32768 : mix;
        o   = (sat * longint'(vol)) >>> 8;
        return {(sat != mix), 16'(o)};
    endfunction

    int          m_cnt   = 0;
    logic [16:0] m_res   = '0;
    logic        m_valid = 1'b0;
    logic [15:0] m_out   = '0;
    logic        m_clip  = 1'b0;
    logic        m_ovr   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt   <= 0;
            m_valid <= 1'b0;
            m_out   <= '0;
            m_clip  <= 1'b0;
            m_ovr   <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            if (m_cnt == 0) begin
                if (sample_tick) begin
                    m_cnt <= NUM_CH + 1;
                    m_res <= mix_model(ch_pcm, ch_gain, ch_en, master_vol);
                end
            end else begin
                if (m_cnt == 1) begin
                    m_valid <= 1'b1;
                    m_out   <= m_res[15:0];
                    m_clip  <= m_res[16];
                end
                m_cnt <= m_cnt - 1;
            end
            if (sample_tick && m_cnt != 0) m_ovr <= 1'b1;
            else if (clr_overrun)          m_ovr <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("pcm_valid", longint'(pcm_valid), longint'(m_valid));
        chk("busy", longint'(busy), longint'(m_cnt != 0));
        chk("overrun", longint'(overrun), longint'(m_ovr));
        chk("pcm_out", longint'($signed(pcm_out)), longint'($signed(m_out)));
        chk("clip", longint'(clip), longint'(m_clip));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input int pcm, input int gain, input bit en);
        ch_pcm[16*i +: 16] = 16'(pcm);
        ch_gain[8*i +: 8]  = 8'(gain);
        ch_en[i]           = en;
    endtask

    task automatic clear_ch();
        ch_pcm  = '0;
        ch_gain = '0;
        ch_en   = '0;
    endtask

    task automatic wait_valid(input int start, output int lat);
        lat = start;
        while (!pcm_valid && lat < 30) begin
            step();
            lat++;
        end
        if (!pcm_valid) lat = -1;
    endtask

    task automatic run_tick(input bit mutate, output int lat);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        if (mutate)
            for (int i = 0; i < NUM_CH; i++) ch_pcm[16*i +: 16] = 16'($urandom);
        wait_valid(1, lat);
        chk("latency", lat, NUM_CH + 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        rst_n       = 1'b0;
        sample_tick = 1'b0;
        clr_overrun = 1'b0;
        master_vol  = '0;
        clear_ch();

        // 1: reset with random inputs
        for (int k = 0; k < 6; k++) begin
            sample_tick = 1'($urandom);
            clr_overrun = 1'($urandom);
            master_vol  = 8'($urandom);
            ch_en       = NUM_CH'($urandom);
            for (int i = 0; i < NUM_CH; i++) begin
                ch_pcm[16*i +: 16] = 16'($urandom);
                ch_gain[8*i +: 8]  = 8'($urandom);
            end
            step();
            chk("rst_pcm_out", longint'(pcm_out), 0);
            chk("rst_valid", longint'(pcm_valid), 0);
            chk("rst_busy", longint'(busy), 0);
            chk("rst_overrun", longint'(overrun), 0);
            chk("rst_clip", longint'(clip), 0);
        end
        sample_tick = 1'b0;
        clr_overrun = 1'b0;
        rst_n       = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("idle_valid", longint'(pcm_valid), 0);
        end

        // 2: single channel at half gain
        clear_ch();
        set_ch(0, 16384, 128, 1'b1);
        set_ch(1, 1000, 200, 1'b0);
        master_vol = 8'd255;
        run_tick(1'b0, lat);
        chk("t2_out", longint'($signed(pcm_out)), 8160);
        chk("t2_clip", longint'(clip), 0);
        step();
        chk("t2_valid_pulse", longint'(pcm_valid), 0);

        // 3: positive and negative full-scale saturation
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 32767, 255, 1'b1);
        run_tick(1'b0, lat);
        chk("t3_pos_out", longint'($signed(pcm_out)), 32639);
        chk("t3_pos_clip", longint'(clip), 1);
        for (int i = 0; i < NUM_CH; i++) set_ch(i, -32768, 255, 1'b1);
        run_tick(1'b0, lat);
        chk("t3_neg_out", longint'($signed(pcm_out)), -32640);
        chk("t3_neg_clip", longint'(clip), 1);

        // 4: master volume scaling, then snapshot isolation
        clear_ch();
        set_ch(0, -32768, 255, 1'b1);
        master_vol = 8'd128;
        run_tick(1'b0, lat);
        chk("t4_out", longint'($signed(pcm_out)), -16320);
        chk("t4_clip", longint'(clip), 0);
        run_tick(1'b1, lat);
        chk("t4_snap_out", longint'($signed(pcm_out)), -16320);

        // all channels disabled, and zero master volume
        clear_ch();
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 30000, 255, 1'b0);
        master_vol = 8'd255;
        run_tick(1'b0, lat);
        chk("t4_alloff_out", longint'($signed(pcm_out)), 0);
        chk("t4_alloff_clip", longint'(clip), 0);
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 30000, 255, 1'b1);
        master_vol = 8'd0;
        run_tick(1'b0, lat);
        chk("t4_vol0_out", longint'($signed(pcm_out)), 0);
        chk("t4_vol0_clip", longint'(clip), 1);

        // 5: overrun handling and back-to-back ticks
        clear_ch();
        set_ch(2, -1234, 77, 1'b1);
        set_ch(3, 5000, 3, 1'b1);
        master_vol  = 8'd200;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        wait_valid(4, lat);
        chk("t5_latency", lat, NUM_CH + 2);
        chk("t5_overrun_set", longint'(overrun), 1);
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        sample_tick = 1'b1;
        clr_overrun = 1'b1;
        step();
        sample_tick = 1'b0;
        clr_overrun = 1'b0;
        chk("t5_set_wins", longint'(overrun), 1);
        wait_valid(3, lat);
        chk("t5_latency2", lat, NUM_CH + 2);
        step();
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        chk("t5_overrun_clr", longint'(overrun), 0);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        for (int k = 0; k < NUM_CH + 1; k++) step();
        chk("t5_b2b_valid1", longint'(pcm_valid), 1);
        run_tick(1'b0, lat);
        chk("t5_b2b_overrun", longint'(overrun), 0);

        // 6: reset mid-sequence
        clear_ch();
        set_ch(0, -32768, 255, 1'b1);
        master_vol  = 8'd128;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        step();
        chk("t6_busy", longint'(busy), 0);
        chk("t6_valid", longint'(pcm_valid), 0);
        chk("t6_pcm_out", longint'(pcm_out), 0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) step();
        run_tick(1'b0, lat);
        chk("t6_out", longint'($signed(pcm_out)), -16320);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
